instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Encoder counterpart to the control decoder. Accepts symbolic instruction requests (operation select plus register and immediate fields) over a valid/ready handshake and encodes each into a 32-bit LEGv8 machine word. Writes the words sequentially into instruction memory through a write port. Used by benches and the boot path to load programs without a pre-assembled image.

Parameters:
ADDR_W, 64, width of instruction-memory byte address
BASE_ADDR, 0, byte address of first word written after start
MEM_DEPTH, 64, max words per load session; must be ≥1
CNT_W, 7, width of word_count; must be ≥ clog2(MEM_DEPTH+1)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
start  in  1  begin load session (pulse)
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_last  in  1  request is final of session
req_op  in  4  0 AND, 1 ORR, 2 ADD, 3 SUB, 4 ADDI, 5 SUBI, 6 MOVZ, 7 B, 8 CBZ, 9 LDUR, 10 STUR, 11-15 illegal
req_rd  in  5  Rd/Rt
req_rn  in  5  Rn
req_rm  in  5  Rm
req_imm  in  26  immediate source
imem_we  out  1  write strobe
imem_addr  out  ADDR_W  byte address of write
imem_wdata  out  32  encoded word
busy  out  1  in ACCEPT state
done  out  1  in DONE state
err  out  1  sticky: illegal op seen this session
overflow  out  1  sticky: MEM_DEPTH reached without req_last
word_count  out  CNT_W  words written this session

Behaviour:
- Reset: state IDLE, all outputs 0, internal address = BASE_ADDR. Reset mid-session aborts immediately; any pending write is dropped.
- FSM states: IDLE, ACCEPT, DONE.
- IDLE/DONE + start: go to ACCEPT; clear addr to BASE_ADDR, word_count, err, overflow.
- start while in ACCEPT: ignored.
- req_ready = (state==ACCEPT) && (word_count < MEM_DEPTH).
- Transfer occurs on an edge where req_valid && req_ready.
- Write timing: for a legal op accepted at edge N, imem_we is 1 for exactly the cycle after edge N. imem_addr/imem_wdata are registered and valid in that cycle.
- After each write: addr += 4, word_count += 1.
- Throughput: back-to-back, one transfer per cycle.
- Illegal op: handshake completes; no write; addr and word_count unchanged; err set.
- Transfer with req_last=1: state goes to DONE on that edge. Its write, if legal, still occurs in the following cycle.
- Overflow: legal transfer without req_last that makes word_count == MEM_DEPTH sets overflow, and state goes to DONE.
- req_last on the final slot: no overflow.
- Encoding; unused bits 0; immediate fields are truncated from req_imm with no range check:
  - R-type (ops 0-3): opc11[31:21], Rm[20:16], shamt=0, Rn[9:5], Rd[4:0]. opc11 = 10001010000 / 10101010000 / 10001011000 / 11001011000.
  - I-type (ADDI/SUBI): opc10[31:22] = 1001000100 / 1101000100, imm[11:0]→[21:10], Rn, Rd.
  - MOVZ: 110100101[31:23], hw = imm[17:16]→[22:21], imm[15:0]→[20:5], Rd.
  - B: 000101[31:26], imm[25:0].
  - CBZ: 10110100[31:24], imm[18:0]→[23:5], Rt = req_rd.
  - LDUR/STUR: 11111000010 / 11111000000 [31:21], imm[8:0]→[20:12], op2=00, Rn, Rt = req_rd.
- imem_addr wraps modulo 2^ADDR_W.

Test Plan:
- Reset, start, send ADD rd=3 rn=1 rm=2 with req_last=1 → one imem_we cycle with addr 0x0, wdata 0x8B020023; then done=1, word_count=1.
- Back-to-back stream with req_valid held high: ADDI rd1 rn31 imm5; LDUR rd2 rn1 imm8; CBZ rd5 imm 0x7FFFE; B imm3; MOVZ rd4 imm 0x11234 (last) → wdata 0x910017E1, 0xF8408022, 0xB4FFFFC5, 0x14000003, 0xD2A24684 at addr 0, 4, 8, C, 10 on consecutive cycles; word_count=5.
- Illegal op 12 between two ADDs → only 2 writes, at addr 0 and 4; err=1; err clears on next start.
- MEM_DEPTH=4, send 5 requests without req_last → 4 writes; overflow=1; req_ready=0 from the 4th transfer onward; done=1.
- Assert Reset mid-stream, in the cycle after an accepted transfer → no imem_we; all outputs 0; a new start writes from BASE_ADDR.
- start asserted during ACCEPT → no effect on addr or word_count; with req_valid=0 held, no writes occur.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Accepts symbolic LEGv8 instruction requests over a valid/ready handshake.
// Each request is encoded into a 32-bit machine word, and the word is written
// sequentially into instruction memory through a simple write port.
//
// Ports:
//   Clk         rising-edge clock
//   Reset       asynchronous, active-high reset
//   start       pulse that begins a load session (ignored while accepting)
//   req_valid   request present
//   req_ready   block can accept a request
//   req_last    request is the final one of the session
//   req_op      operation select (0..10 legal, 11..15 illegal)
//   req_rd      Rd / Rt field
//   req_rn      Rn field
//   req_rm      Rm field
//   req_imm     immediate source (truncated per format)
//   imem_we     write strobe, one cycle per legal accepted request
//   imem_addr   byte address of the write
//   imem_wdata  encoded instruction word
//   busy        session is accepting requests
//   done        session has finished
//   err         sticky: an illegal op was seen this session
//   overflow    sticky: MEM_DEPTH words written without req_last
//   word_count  words written this session
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
    parameter int                MEM_DEPTH = 64,
    parameter int                CNT_W     = 7
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_last,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rn,
    input  logic [4:0]        req_rm,
    input  logic [25:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              overflow,
    output logic [CNT_W-1:0]  word_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] STEP_C = {{(ADDR_W-3){1'b0}}, 3'b100};

    // Returns {legal, word}; legal is 0 for unsupported op codes.
    function automatic logic [32:0] encode_word(
        input logic [3:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rn,
        input logic [4:0]  rm,
        input logic [25:0] imm
    );
        logic [32:0] res;
        res = {1'b1, 32'h0000_0000};
        case (op)
            4'd0:    res[31:0] = {11'b10001010000, rm, 6'b000000, rn, rd};
            4'd1:    res[31:0] = {11'b10101010000, rm, 6'b000000, rn, rd};
            4'd2:    res[31:0] = {11'b10001011000, rm, 6'b000000, rn, rd};
            4'd3:    res[31:0] = {11'b11001011000, rm, 6'b000000, rn, rd};
            4'd4:    res[31:0] = {10'b1001000100, imm[11:0], rn, rd};
            4'd5:    res[31:0] = {10'b1101000100, imm[11:0], rn, rd};
            4'd6:    res[31:0] = {9'b110100101, imm[17:16], imm[15:0], rd};
            4'd7:    res[31:0] = {6'b000101, imm[25:0]};
            4'd8:    res[31:0] = {8'b10110100, imm[18:0], rd};
            4'd9:    res[31:0] = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
            4'd10:   res[31:0] = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
            default: res       = {1'b0, 32'h0000_0000};
        endcase
        return res;
    endfunction

    logic [1:0]        state_r, state_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              err_r, err_nxt_s;
    logic              ovf_r, ovf_nxt_s;
    logic              we_r, we_nxt_s;
    logic [ADDR_W-1:0] waddr_r, waddr_nxt_s;
    logic [31:0]       wdata_r, wdata_nxt_s;
    logic              ready_r, ready_nxt_s;
    logic              busy_r, done_r;
    logic              fire_s;
    logic [32:0]       enc_s;

    assign fire_s = req_valid && ready_r;
    assign enc_s  = encode_word(req_op, req_rd, req_rn, req_rm, req_imm);

    // Next-state, session bookkeeping and write-port staging.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        cnt_nxt_s   = cnt_r;
        err_nxt_s   = err_r;
        ovf_nxt_s   = ovf_r;
        we_nxt_s    = 1'b0;
        waddr_nxt_s = waddr_r;
        wdata_nxt_s = wdata_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_ACCEPT;
                    addr_nxt_s  = BASE_ADDR;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    err_nxt_s   = 1'b0;
                    ovf_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_ACCEPT: begin
                if (fire_s) begin
                    if (enc_s[32]) begin
                        we_nxt_s    = 1'b1;
                        waddr_nxt_s = addr_r;
                        wdata_nxt_s = enc_s[31:0];
                        addr_nxt_s  = addr_r + STEP_C;
                        cnt_nxt_s   = cnt_r + ONE_C;
                    end else begin
                        err_nxt_s   = 1'b1;
                    end
                    // req_last wins over overflow when it lands on the final slot.
                    if (req_last) begin
                        state_nxt_s = ST_DONE;
                    end else if (enc_s[32] && (cnt_nxt_s == DEPTH_C)) begin
                        ovf_nxt_s   = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ACCEPT;
                    end
                end else begin
                    state_nxt_s = ST_ACCEPT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        ready_nxt_s = (state_nxt_s == ST_ACCEPT) && (cnt_nxt_s < DEPTH_C);
    end

    // State and output registers; reset drops any pending write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            addr_r  <= BASE_ADDR;
            cnt_r   <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
            ovf_r   <= 1'b0;
            we_r    <= 1'b0;
            waddr_r <= {ADDR_W{1'b0}};
            wdata_r <= 32'h0000_0000;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            err_r   <= err_nxt_s;
            ovf_r   <= ovf_nxt_s;
            we_r    <= we_nxt_s;
            waddr_r <= waddr_nxt_s;
            wdata_r <= wdata_nxt_s;
            ready_r <= ready_nxt_s;
            busy_r  <= (state_nxt_s == ST_ACCEPT);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign req_ready  = ready_r;
    assign imem_we    = we_r;
    assign imem_addr  = waddr_r;
    assign imem_wdata = wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign overflow   = ovf_r;
    assign word_count = cnt_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// Testbench for instr_encoder_loader: directed steps followed by randomized
// sessions, all checked cycle by cycle against a session-level model.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start, req_valid, req_last;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [4:0]  req_rd, req_rn, req_rm;
    logic [25:0] req_imm;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy, done, err, overflow;
    logic [CW-1:0] word_count;

    int compared = 0;
    int mismatched = 0;

    // model state: mode 0 = idle, 1 = accepting, 2 = finished
    int          m_mode;
    int          m_cnt;
    longint unsigned m_addr;
    bit          m_err, m_ovf, m_we;
    longint unsigned m_waddr;
    logic [31:0] m_wdata;

    instr_encoder_loader #(.ADDR_W(64), .BASE_ADDR(64'h0), .MEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .req_valid(req_valid),
        .req_ready(req_ready), .req_last(req_last), .req_op(req_op),
        .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm), .req_imm(req_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .overflow(overflow),
        .word_count(word_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Encoding written as field-value times place-value sums.
    function automatic longint unsigned ref_word(input int op, input int rd, input int rn,
                                                 input int rm, input longint unsigned imm);
        longint unsigned w;
        case (op)
            0: w = 64'd1104 * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
            1: w = 64'd1360 * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
            2: w = 64'd1112 * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
            3: w = 64'd1624 * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
            4: w = 64'd580 * (64'd1 << 22) + (imm % 4096) * 1024 + rn * 32 + rd;
            5: w = 64'd836 * (64'd1 << 22) + (imm % 4096) * 1024 + rn * 32 + rd;
            6: w = 64'd421 * (64'd1 << 23) + ((imm / 65536) % 4) * (64'd1 << 21)
                   + (imm % 65536) * 32 + rd;
            7: w = 64'd5 * (64'd1 << 26) + imm % (64'd1 << 26);
            8: w = 64'd180 * (64'd1 << 24) + (imm % (64'd1 << 19)) * 32 + rd;
            9: w = 64'd1986 * (64'd1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
            10: w = 64'd1984 * (64'd1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
            default: w = 64'd0;
        endcase
        return w;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_addr = 64'd0; m_err = 1'b0; m_ovf = 1'b0; m_we = 1'b0;
    endtask

    task automatic drive(input bit s, input bit v, input bit l, input int op,
                         input int rd, input int rn, input int rm, input int imm);
        start = s; req_valid = v; req_last = l; req_op = 4'(op);
        req_rd = 5'(rd); req_rn = 5'(rn); req_rm = 5'(rm); req_imm = 26'(imm);
    endtask

    // One clock: check ready before the edge, advance the model, check after.
    task automatic cycle(input bit s, input bit v, input bit l, input int op,
                         input int rd, input int rn, input int rm, input int imm);
        bit rdy, fire;
        drive(s, v, l, op, rd, rn, rm, imm);
        rdy  = (m_mode == 1) && (m_cnt < DEPTH);
        fire = v && rdy;
        check("ready_pre", {63'd0, req_ready}, {63'd0, rdy});
        @(posedge Clk);
        m_we = 1'b0;
        if (m_mode != 1 && s) begin
            m_mode = 1; m_addr = 64'd0; m_cnt = 0; m_err = 1'b0; m_ovf = 1'b0;
        end else if (fire) begin
            if (op <= 10) begin
                m_we = 1'b1; m_waddr = m_addr;
                m_wdata = 32'(ref_word(op, rd, rn, rm, longint'(imm) & 64'h3FF_FFFF));
                m_addr = m_addr + 64'd4; m_cnt++;
            end else begin
                m_err = 1'b1;
            end
            if (l) m_mode = 2;
            else if (op <= 10 && m_cnt == DEPTH) begin m_ovf = 1'b1; m_mode = 2; end
        end
        #1;
        check("imem_we", {63'd0, imem_we}, {63'd0, m_we});
        if (m_we) begin
            check("imem_addr", imem_addr, m_waddr);
            check("imem_wdata", {32'd0, imem_wdata}, {32'd0, m_wdata});
        end
        check("busy", {63'd0, busy}, {63'd0, m_mode == 1});
        check("done", {63'd0, done}, {63'd0, m_mode == 2});
        check("err", {63'd0, err}, {63'd0, m_err});
        check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        check("word_count", {60'd0, word_count}, 64'(m_cnt));
        check("ready_post", {63'd0, req_ready}, {63'd0, (m_mode == 1) && (m_cnt < DEPTH)});
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, {63'd0, imem_we}, 64'd0);
        check({tag, "_addr"}, imem_addr, 64'd0);
        check({tag, "_wdata"}, {32'd0, imem_wdata}, 64'd0);
        check({tag, "_flags"}, {58'd0, req_ready, busy, done, err, overflow, 1'b0}, 64'd0);
        check({tag, "_count"}, {60'd0, word_count}, 64'd0);
    endtask

    initial begin
        int n;
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all_zero("reset");
        Reset = 1'b0;
        idle_cycle();

        // single ADD with req_last
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        cycle(1'b0, 1'b1, 1'b1, 2, 3, 1, 2, 0);
        check("add_word", {32'd0, imem_wdata}, 64'h8B02_0023);
        check("add_addr", imem_addr, 64'h0);
        idle_cycle();
        check("add_done", {63'd0, done}, 64'd1);

        // back-to-back stream
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        cycle(1'b0, 1'b1, 1'b0, 4, 1, 31, 0, 5);
        check("s0", {32'd0, imem_wdata}, 64'h9100_17E1);
        cycle(1'b0, 1'b1, 1'b0, 9, 2, 1, 0, 8);
        check("s1", {32'd0, imem_wdata}, 64'hF840_8022);
        cycle(1'b0, 1'b1, 1'b0, 8, 5, 0, 0, 32'h7FFFE);
        check("s2", {32'd0, imem_wdata}, 64'hB4FF_FFC5);
        cycle(1'b0, 1'b1, 1'b0, 7, 0, 0, 0, 3);
        check("s3", {32'd0, imem_wdata}, 64'h1400_0003);
        cycle(1'b0, 1'b1, 1'b1, 6, 4, 0, 0, 32'h11234);
        check("s4", {32'd0, imem_wdata}, 64'hD2A2_4684);
        check("s4_addr", imem_addr, 64'h10);
        check("s_count", {60'd0, word_count}, 64'd5);
        idle_cycle();

        // illegal op between two ADDs, then err clears on restart
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        cycle(1'b0, 1'b1, 1'b0, 2, 1, 2, 3, 0);
        cycle(1'b0, 1'b1, 1'b0, 12, 1, 2, 3, 0);
        check("ill_no_we", {63'd0, imem_we}, 64'd0);
        cycle(1'b0, 1'b1, 1'b1, 2, 4, 5, 6, 0);
        check("ill_addr2", imem_addr, 64'h4);
        idle_cycle();
        check("ill_err", {63'd0, err}, 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        check("err_clear", {63'd0, err}, 64'd0);

        // overflow: DEPTH+1 requests without req_last
        for (int i = 0; i <= DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 1, i, i, i, 0);
        check("ovf_flag", {63'd0, overflow}, 64'd1);
        check("ovf_count", {60'd0, word_count}, 64'(DEPTH));
        idle_cycle();

        // reset in the cycle after an accepted transfer
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        cycle(1'b0, 1'b1, 1'b0, 2, 7, 7, 7, 0);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        idle_cycle();
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        cycle(1'b0, 1'b1, 1'b0, 3, 1, 1, 1, 0);
        check("after_rst_addr", imem_addr, 64'h0);

        // start during ACCEPT is ignored
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        check("start_ign_cnt", {60'd0, word_count}, 64'd1);
        cycle(1'b0, 1'b1, 1'b1, 0, 2, 2, 2, 0);
        check("start_ign_addr", imem_addr, 64'h4);

        // randomized sessions
        for (int s = 0; s < 12; s++) begin
            cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
            n = 0;
            while (m_mode == 1 && n < 40) begin
                cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 15),
                      $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), int'($urandom() & 32'h3FF_FFFF));
                n++;
            end
            check("rand_ended", {63'd0, m_mode == 1}, 64'd0);
            idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
